// File: rtl/ccu_clk_slice_ctrl_pkg.sv
// Shared state type, default delays and per-state helpers for the clock slice controller.
package ccu_clk_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_REQ_WAIT,
      ST_PRE_ACK,
      ST_ACKED,
      ST_ACK0_WAIT,
      ST_GATING
   } ccu_slice_state_e;

   localparam int DEF_NUM_SLICES   = 1;
   localparam int DEF_REQ1_CLK1    = 4;
   localparam int DEF_CLK1_ACK1    = 2;
   localparam int DEF_REQ0_ACK0    = 2;
   localparam int DEF_ACK0_CLK0    = 8;
   localparam int DEF_USYNC_PERIOD = 16;
   localparam int DEF_CNT_W        = 8;

   // Timed states leave on the terminal count; OFF and ACKED only watch clkreq.
   function automatic ccu_slice_state_e slice_next(input ccu_slice_state_e st,
                                                   input logic             cnt_tc,
                                                   input logic             req);
      ccu_slice_state_e nxt;
      nxt = st;
      case (st)
         ST_OFF:       if (req)     nxt = ST_REQ_WAIT;
         ST_REQ_WAIT:  if (cnt_tc)  nxt = ST_PRE_ACK;
         ST_PRE_ACK:   if (cnt_tc)  nxt = ST_ACKED;
         ST_ACKED:     if (!req)    nxt = ST_ACK0_WAIT;
         ST_ACK0_WAIT: if (cnt_tc)  nxt = ST_GATING;
         ST_GATING:    if (cnt_tc)  nxt = ST_OFF;
         default:                   nxt = ST_OFF;
      endcase
      return nxt;
   endfunction

   function automatic logic state_clk_en(input ccu_slice_state_e st);
      return st inside {ST_PRE_ACK, ST_ACKED, ST_ACK0_WAIT, ST_GATING};
   endfunction

   function automatic logic state_clkack(input ccu_slice_state_e st);
      return st inside {ST_ACKED, ST_ACK0_WAIT};
   endfunction

endpackage

// File: rtl/ccu_clk_slice_ctrl_if.sv
// Agent-facing clock request/acknowledge bundle for all slices plus the usync strobes.
interface ccu_clk_slice_ctrl_if #(
   parameter int NUM_SLICES = 1
);
   logic [NUM_SLICES-1:0] clkreq;
   logic [NUM_SLICES-1:0] clkack;
   logic [NUM_SLICES-1:0] clk_en;
   logic [NUM_SLICES-1:0] usync;
   logic [NUM_SLICES-1:0] proto_err;
   logic                  globalusync;

   modport master (
      output clkreq,
      input  clkack, clk_en, usync, proto_err, globalusync
   );

   modport slave (
      input  clkreq,
      output clkack, clk_en, usync, proto_err, globalusync
   );
endinterface

// File: rtl/ccu_clk_slice_ctrl_fsm.sv
// One clock slice: 4-phase clkreq/clkack handshake with programmable delays.
//
// state        | meaning
// -------------+----------------------------------------------------
// ST_OFF       | slice clock gated, waiting for clkreq
// ST_REQ_WAIT  | request seen, counting REQ1_CLK1 before enabling
// ST_PRE_ACK   | clock running, counting CLK1_ACK1 before acking
// ST_ACKED     | acknowledged, waiting for clkreq to drop
// ST_ACK0_WAIT | request dropped, counting REQ0_ACK0 before unacking
// ST_GATING    | ack removed, counting ACK0_CLK0 before gating clock
module ccu_slice_fsm
   import ccu_clk_pkg::*;
#(
   parameter int REQ1_CLK1 = DEF_REQ1_CLK1,
   parameter int CLK1_ACK1 = DEF_CLK1_ACK1,
   parameter int REQ0_ACK0 = DEF_REQ0_ACK0,
   parameter int ACK0_CLK0 = DEF_ACK0_CLK0,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic clkreq,
   input  logic usync_tick,
   output logic clk_en,
   output logic clkack,
   output logic usync,
   output logic proto_err
);

   // A zero delay still occupies its state for one cycle.
   localparam logic [CNT_W-1:0] LD_REQ1_CLK1 = (REQ1_CLK1 == 0) ? CNT_W'(1) : CNT_W'(REQ1_CLK1);
   localparam logic [CNT_W-1:0] LD_CLK1_ACK1 = (CLK1_ACK1 == 0) ? CNT_W'(1) : CNT_W'(CLK1_ACK1);
   localparam logic [CNT_W-1:0] LD_REQ0_ACK0 = (REQ0_ACK0 == 0) ? CNT_W'(1) : CNT_W'(REQ0_ACK0);
   localparam logic [CNT_W-1:0] LD_ACK0_CLK0 = (ACK0_CLK0 == 0) ? CNT_W'(1) : CNT_W'(ACK0_CLK0);

   ccu_slice_state_e state;
   ccu_slice_state_e state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_load;
   logic             cnt_tc;

   assign cnt_tc    = (cnt == CNT_W'(1));
   assign state_nxt = slice_next(state, cnt_tc, clkreq);

   always_comb begin
      cnt_load = '0;
      case (state_nxt)
         ST_REQ_WAIT:  cnt_load = LD_REQ1_CLK1;
         ST_PRE_ACK:   cnt_load = LD_CLK1_ACK1;
         ST_ACK0_WAIT: cnt_load = LD_REQ0_ACK0;
         ST_GATING:    cnt_load = LD_ACK0_CLK0;
         default:      cnt_load = '0;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_OFF;
         cnt       <= '0;
         clk_en    <= 1'b0;
         clkack    <= 1'b0;
         usync     <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state  <= state_nxt;
         clk_en <= state_clk_en(state_nxt);
         clkack <= state_clkack(state_nxt);
         usync  <= usync_tick & state_clk_en(state_nxt);
         if (state_nxt != state) begin
            cnt <= cnt_load;
         end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (!clkreq && (state == ST_REQ_WAIT || state == ST_PRE_ACK)) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ccu_clk_slice_ctrl.sv
// Multi-slice clock control unit: per-slice handshake FSMs and the shared usync timebase.
module ccu_clk_slice_ctrl
   import ccu_clk_pkg::*;
#(
   parameter int NUM_SLICES   = DEF_NUM_SLICES,
   parameter int REQ1_CLK1    = DEF_REQ1_CLK1,
   parameter int CLK1_ACK1    = DEF_CLK1_ACK1,
   parameter int REQ0_ACK0    = DEF_REQ0_ACK0,
   parameter int ACK0_CLK0    = DEF_ACK0_CLK0,
   parameter int USYNC_PERIOD = DEF_USYNC_PERIOD,
   parameter int CNT_W        = DEF_CNT_W
) (
   input logic                 clk,
   input logic                 reset,
   ccu_clk_slice_ctrl_if.slave bus
);

   localparam int                 USYNC_W    = (USYNC_PERIOD > 1) ? $clog2(USYNC_PERIOD) : 1;
   localparam logic [USYNC_W-1:0] USYNC_LAST = USYNC_W'(USYNC_PERIOD - 1);

   logic [USYNC_W-1:0]    usync_cnt;
   logic [USYNC_W-1:0]    usync_cnt_nxt;
   logic                  usync_tick;
   logic                  globalusync_q;
   logic [NUM_SLICES-1:0] clkack_w;
   logic [NUM_SLICES-1:0] clk_en_w;
   logic [NUM_SLICES-1:0] usync_w;
   logic [NUM_SLICES-1:0] proto_err_w;

   assign usync_cnt_nxt = (usync_cnt == USYNC_LAST) ? '0 : usync_cnt + USYNC_W'(1);
   // Slices register their usync from this same look-ahead so both strobes line up.
   assign usync_tick    = (usync_cnt_nxt == USYNC_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         usync_cnt     <= '0;
         globalusync_q <= 1'b0;
      end else begin
         usync_cnt     <= usync_cnt_nxt;
         globalusync_q <= usync_tick;
      end
   end

   for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slice
      ccu_slice_fsm #(
         .REQ1_CLK1 (REQ1_CLK1),
         .CLK1_ACK1 (CLK1_ACK1),
         .REQ0_ACK0 (REQ0_ACK0),
         .ACK0_CLK0 (ACK0_CLK0),
         .CNT_W     (CNT_W)
      ) u_slice (
         .clk        (clk),
         .reset      (reset),
         .clkreq     (bus.clkreq[g]),
         .usync_tick (usync_tick),
         .clk_en     (clk_en_w[g]),
         .clkack     (clkack_w[g]),
         .usync      (usync_w[g]),
         .proto_err  (proto_err_w[g])
      );
   end

   assign bus.clkack      = clkack_w;
   assign bus.clk_en      = clk_en_w;
   assign bus.usync       = usync_w;
   assign bus.proto_err   = proto_err_w;
   assign bus.globalusync = globalusync_q;

endmodule

// File: tb/tb_ccu_clk_slice_ctrl.sv
// Bench for ccu_clk_slice_ctrl: a 4-slice default instance and a 1-slice zero-delay instance.
module tb_ccu_clk_slice_ctrl;

   localparam longint INF = 64'd1000000000;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   // Per-instance configuration: index 0 = dut_a, index 1 = dut_z (raw delay values).
   int cfg_ns[2] = '{4, 1};
   int cfg_l1[2] = '{4, 0};
   int cfg_l2[2] = '{2, 0};
   int cfg_l3[2] = '{2, 0};
   int cfg_l4[2] = '{8, 0};
   int cfg_p[2]  = '{16, 2};

   // Model: each handshake is a set of absolute edge numbers at which its outputs change.
   longint cyc = 0;
   longint rst_edge = 0;
   bit     rst_seen = 1'b0;
   bit     m_act [2][4];
   bit     m_err [2][4];
   longint m_en1 [2][4];
   longint m_ack1[2][4];
   longint m_ack0[2][4];
   longint m_en0 [2][4];

   ccu_clk_slice_ctrl_if #(.NUM_SLICES(4)) bus_a ();
   ccu_clk_slice_ctrl_if #(.NUM_SLICES(1)) bus_z ();

   ccu_clk_slice_ctrl #(
      .NUM_SLICES(4), .REQ1_CLK1(4), .CLK1_ACK1(2), .REQ0_ACK0(2), .ACK0_CLK0(8),
      .USYNC_PERIOD(16), .CNT_W(8)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   ccu_clk_slice_ctrl #(
      .NUM_SLICES(1), .REQ1_CLK1(0), .CLK1_ACK1(0), .REQ0_ACK0(0), .ACK0_CLK0(0),
      .USYNC_PERIOD(2), .CNT_W(8)
   ) dut_z (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_z)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic longint eff(input int v);
      return (v == 0) ? 64'd1 : longint'(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_edges(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   // Model update on every edge and full output compare 1 time unit after it.
   initial begin
      logic       r_s;
      logic [3:0] rq [2];
      logic [3:0] e_en, e_ack, e_us, e_err, d_en, d_ack, d_us, d_err;
      logic       e_g, d_g;
      string      pfx;
      forever begin
         @(posedge clk);
         cyc++;
         r_s   = reset;
         rq[0] = bus_a.clkreq;
         rq[1] = {3'b000, bus_z.clkreq};
         if (r_s) begin
            rst_seen = 1'b1;
            rst_edge = cyc;
            for (int d = 0; d < 2; d++)
               for (int s = 0; s < 4; s++) begin
                  m_act[d][s] = 1'b0;
                  m_err[d][s] = 1'b0;
               end
         end else begin
            for (int d = 0; d < 2; d++)
               for (int s = 0; s < cfg_ns[d]; s++) begin
                  if (m_act[d][s] && cyc > m_en0[d][s]) m_act[d][s] = 1'b0;
                  if (!m_act[d][s]) begin
                     if (rq[d][s]) begin
                        m_act[d][s]  = 1'b1;
                        m_en1[d][s]  = cyc + eff(cfg_l1[d]);
                        m_ack1[d][s] = m_en1[d][s] + eff(cfg_l2[d]);
                        m_ack0[d][s] = INF;
                        m_en0[d][s]  = INF;
                     end
                  end else if (m_ack0[d][s] == INF && !rq[d][s]) begin
                     if (cyc <= m_ack1[d][s]) begin
                        m_err[d][s] = 1'b1;
                     end else begin
                        m_ack0[d][s] = cyc + eff(cfg_l3[d]);
                        m_en0[d][s]  = m_ack0[d][s] + eff(cfg_l4[d]);
                     end
                  end
               end
         end
         #1;
         if (rst_seen) begin
            for (int d = 0; d < 2; d++) begin
               e_en = '0; e_ack = '0; e_us = '0; e_err = '0;
               e_g  = ((cyc - rst_edge) % longint'(cfg_p[d])) == longint'(cfg_p[d] - 1);
               for (int s = 0; s < cfg_ns[d]; s++) begin
                  e_en[s]  = m_act[d][s] && cyc >= m_en1[d][s] && cyc < m_en0[d][s];
                  e_ack[s] = m_act[d][s] && cyc >= m_ack1[d][s] && cyc < m_ack0[d][s];
                  e_us[s]  = e_g & e_en[s];
                  e_err[s] = m_err[d][s];
               end
               if (d == 0) begin
                  pfx = "a"; d_en = bus_a.clk_en; d_ack = bus_a.clkack; d_us = bus_a.usync;
                  d_err = bus_a.proto_err; d_g = bus_a.globalusync;
               end else begin
                  pfx = "z"; d_en = {3'b000, bus_z.clk_en}; d_ack = {3'b000, bus_z.clkack};
                  d_us = {3'b000, bus_z.usync}; d_err = {3'b000, bus_z.proto_err};
                  d_g = bus_z.globalusync;
               end
               chk({pfx, "_model_clk_en"},      32'(d_en),  32'(e_en));
               chk({pfx, "_model_clkack"},      32'(d_ack), 32'(e_ack));
               chk({pfx, "_model_usync"},       32'(d_us),  32'(e_us));
               chk({pfx, "_model_proto_err"},   32'(d_err), 32'(e_err));
               chk({pfx, "_model_globalusync"}, 32'(d_g),   32'(e_g));
            end
         end
      end
   end

   // Directed stimulus with hand-computed literal expectations (E/F/G/H/X are sample edges).
   initial begin
      reset = 1'b1;
      bus_a.clkreq = '0;
      bus_z.clkreq = '0;
      wait_edges(3);
      chk("a_rst_clk_en", 32'(bus_a.clk_en), 32'd0);
      chk("a_rst_clkack", 32'(bus_a.clkack), 32'd0);
      chk("a_rst_perr",   32'(bus_a.proto_err), 32'd0);
      chk("a_rst_gusync", 32'(bus_a.globalusync), 32'd0);
      chk("a_rst_usync",  32'(bus_a.usync), 32'd0);
      chk("z_rst_clk_en", 32'(bus_z.clk_en), 32'd0);
      reset = 1'b0;
      wait_edges(14);
      chk("a_gusync_r14", 32'(bus_a.globalusync), 32'd0);
      chk("z_gusync_r14", 32'(bus_z.globalusync), 32'd0);
      wait_edges(1);
      chk("a_gusync_r15", 32'(bus_a.globalusync), 32'd1);
      chk("z_gusync_r15", 32'(bus_z.globalusync), 32'd1);
      wait_edges(1);
      chk("a_gusync_r16", 32'(bus_a.globalusync), 32'd0);
      chk("z_gusync_r16", 32'(bus_z.globalusync), 32'd0);

      // Basic handshake on a[0] and z, sampled at E.
      bus_a.clkreq[0] = 1'b1;
      bus_z.clkreq[0] = 1'b1;
      wait_edges(2);
      chk("z_en_e1",  32'(bus_z.clk_en), 32'd1);
      chk("z_ack_e1", 32'(bus_z.clkack), 32'd0);
      chk("a_en_e1",  32'(bus_a.clk_en[0]), 32'd0);
      wait_edges(1);
      chk("z_ack_e2", 32'(bus_z.clkack), 32'd1);
      wait_edges(1);
      chk("a_en_e3",  32'(bus_a.clk_en[0]), 32'd0);
      wait_edges(1);
      chk("a_en_e4",  32'(bus_a.clk_en[0]), 32'd1);
      chk("a_ack_e4", 32'(bus_a.clkack[0]), 32'd0);
      wait_edges(1);
      chk("a_ack_e5", 32'(bus_a.clkack[0]), 32'd0);
      wait_edges(1);
      chk("a_ack_e6", 32'(bus_a.clkack[0]), 32'd1);
      wait_edges(13);

      // Drop at F = E+20.
      bus_a.clkreq[0] = 1'b0;
      bus_z.clkreq[0] = 1'b0;
      wait_edges(2);
      chk("z_ack_f1", 32'(bus_z.clkack), 32'd0);
      chk("z_en_f1",  32'(bus_z.clk_en), 32'd1);
      chk("a_ack_f1", 32'(bus_a.clkack[0]), 32'd1);
      wait_edges(1);
      chk("a_ack_f2", 32'(bus_a.clkack[0]), 32'd0);
      chk("a_en_f2",  32'(bus_a.clk_en[0]), 32'd1);
      chk("z_en_f2",  32'(bus_z.clk_en), 32'd0);
      wait_edges(2);
      bus_a.clkreq[0] = 1'b1;       // re-request while a[0] is gating
      wait_edges(6);
      chk("a_en_f10", 32'(bus_a.clk_en[0]), 32'd0);
      wait_edges(4);
      chk("a_en_f14", 32'(bus_a.clk_en[0]), 32'd0);
      wait_edges(1);
      chk("a_en_f15", 32'(bus_a.clk_en[0]), 32'd1);

      // Staggered request on a[3] sampled at G = F+16.
      bus_a.clkreq[3] = 1'b1;
      wait_edges(4);
      chk("a_en_g3", 32'(bus_a.clk_en), 32'h1);
      wait_edges(1);
      chk("a_en_g4", 32'(bus_a.clk_en), 32'h9);
      wait_edges(2);
      chk("a_ack_g6", 32'(bus_a.clkack), 32'h9);

      // Early drop on a[1] and z: request at H, released so it samples low at H+2.
      bus_a.clkreq[1] = 1'b1;
      bus_z.clkreq[0] = 1'b1;
      wait_edges(2);
      chk("a_perr_h1", 32'(bus_a.proto_err), 32'h0);
      chk("z_perr_h1", 32'(bus_z.proto_err), 32'd0);
      chk("z_en_h1",   32'(bus_z.clk_en), 32'd1);
      bus_a.clkreq[1] = 1'b0;
      bus_z.clkreq[0] = 1'b0;
      wait_edges(1);
      chk("a_perr_h2", 32'(bus_a.proto_err), 32'h2);
      chk("z_perr_h2", 32'(bus_z.proto_err), 32'd1);
      chk("z_ack_h2",  32'(bus_z.clkack), 32'd1);
      wait_edges(4);
      chk("a_ack_h6", 32'(bus_a.clkack), 32'hB);
      wait_edges(3);
      chk("a_ack_h9", 32'(bus_a.clkack), 32'h9);
      chk("a_en1_h9", 32'(bus_a.clk_en[1]), 32'd1);
      wait_edges(11);
      chk("a_en_h20",   32'(bus_a.clk_en), 32'h9);
      chk("a_perr_h20", 32'(bus_a.proto_err), 32'h2);
      chk("z_perr_h20", 32'(bus_z.proto_err), 32'd1);
      chk("z_en_h20",   32'(bus_z.clk_en), 32'd0);

      // Reset while a[0] and a[3] are acknowledged; requests stay high.
      reset = 1'b1;
      wait_edges(1);
      chk("a_en_x",   32'(bus_a.clk_en), 32'h0);
      chk("a_ack_x",  32'(bus_a.clkack), 32'h0);
      chk("a_perr_x", 32'(bus_a.proto_err), 32'h0);
      chk("z_perr_x", 32'(bus_z.proto_err), 32'd0);
      reset = 1'b0;
      wait_edges(4);
      chk("a_en_x4",  32'(bus_a.clk_en), 32'h0);
      wait_edges(1);
      chk("a_en_x5",  32'(bus_a.clk_en), 32'h9);
      wait_edges(2);
      chk("a_ack_x7", 32'(bus_a.clkack), 32'h9);
      bus_a.clkreq = '0;
      wait_edges(12);
      chk("a_en_x19", 32'(bus_a.clk_en), 32'h0);
      wait_edges(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
